servo_motion_ctrl: RTL

Slew-limited position sequencer for the safe's lock servo. It accepts lock/unlock commands through a valid/ready handshake and ramps an 8-bit angle (degrees) one degree at a time toward the commanded end position. It then waits a settle time and reports the final lock state. It sits directly upstream of `servo_driver`, and its `angle_pos` output feeds that block's `angle_pos` input.

---
 rtl/servo_motion_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/servo_motion_ctrl.sv
// -----------------------------------------------------------------------------
// servo_motion_ctrl
//
// Slew-limited position sequencer for the safe's lock servo. A lock/unlock
// command is taken over a valid/ready handshake, the commanded angle is ramped
// one degree per STEP_DIV clocks toward the selected end position, the block
// then holds for SETTLE_CYCLES clocks and finally reports the lock state with
// a one-cycle done pulse. After every reset the block performs a settle at the
// locked position before it accepts its first command.
//
// Parameters
//   LOCK_ANGLE     locked end position in degrees (clamped to 0..180)
//   UNLOCK_ANGLE   unlocked end position in degrees (clamped to 0..180)
//   STEP_DIV       clk cycles per 1-degree step (>= 1)
//   SETTLE_CYCLES  clk cycles held at the target before completion (>= 1)
//
// Ports
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   cmd_valid   in   command request
//   cmd_unlock  in   command direction: 1 = unlock, 0 = lock
//   cmd_ready   out  block can accept a command (IDLE)
//   angle_pos   out  commanded servo angle, 0..180, to servo_driver
//   busy        out  motion or settle in progress
//   locked      out  settled at the lock position
//   unlocked    out  settled at the unlock position
//   done        out  one-cycle pulse when a move/settle completes
// -----------------------------------------------------------------------------
module servo_motion_ctrl #(
    parameter int LOCK_ANGLE    = 0,
    parameter int UNLOCK_ANGLE  = 90,
    parameter int STEP_DIV      = 50000,
    parameter int SETTLE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    input  logic       cmd_unlock,
    output logic       cmd_ready,
    output logic [7:0] angle_pos,
    output logic       busy,
    output logic       locked,
    output logic       unlocked,
    output logic       done
);

    // End positions clamped into the mechanical range of the servo.
    localparam int LOCK_CLAMPED   = (LOCK_ANGLE > 180) ? 180 :
                                    ((LOCK_ANGLE < 0) ? 0 : LOCK_ANGLE);
    localparam int UNLOCK_CLAMPED = (UNLOCK_ANGLE > 180) ? 180 :
                                    ((UNLOCK_ANGLE < 0) ? 0 : UNLOCK_ANGLE);

    localparam logic [7:0]  LOCK_POS    = 8'(LOCK_CLAMPED);
    localparam logic [7:0]  UNLOCK_POS  = 8'(UNLOCK_CLAMPED);

    // Terminal counts: the counters start at zero, so the event fires on
    // the STEP_DIV-th / SETTLE_CYCLES-th edge after the counter is cleared.
    localparam logic [31:0] STEP_LAST   = 32'(STEP_DIV - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic [7:0]  angle_q,     angle_d;
    logic [7:0]  target_q,    target_d;
    logic [31:0] step_cnt_q,  step_cnt_d;
    logic [31:0] settle_cnt_q, settle_cnt_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q,      busy_d;
    logic        locked_q,    locked_d;
    logic        unlocked_q,  unlocked_d;
    logic        done_q,      done_d;

    // Next-state logic for the sequencer and all of its registered outputs.
    always_comb begin
        state_d      = state_q;
        angle_d      = angle_q;
        target_d     = target_q;
        step_cnt_d   = step_cnt_q;
        settle_cnt_d = settle_cnt_q;
        locked_d     = locked_q;
        unlocked_d   = unlocked_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    target_d   = cmd_unlock ? UNLOCK_POS : LOCK_POS;
                    locked_d   = 1'b0;
                    unlocked_d = 1'b0;
                    // Already at the requested end: skip straight to the settle.
                    if (target_d == angle_q) begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = 32'd0;
                    end else begin
                        state_d    = ST_MOVE;
                        step_cnt_d = 32'd0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_MOVE: begin
                if (step_cnt_q == STEP_LAST) begin
                    step_cnt_d = 32'd0;
                    // angle never equals target in MOVE, so one of the two
                    // directions always applies and the ramp stays in range.
                    if (target_q > angle_q) begin
                        angle_d = angle_q + 8'd1;
                    end else begin
                        angle_d = angle_q - 8'd1;
                    end
                    if (angle_d == target_q) begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = 32'd0;
                    end else begin
                        state_d = ST_MOVE;
                    end
                end else begin
                    step_cnt_d = step_cnt_q + 32'd1;
                end
            end

            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d    = ST_IDLE;
                    done_d     = 1'b1;
                    // Both flags assert when the two end positions coincide.
                    locked_d   = (target_q == LOCK_POS);
                    unlocked_d = (target_q == UNLOCK_POS);
                end else begin
                    settle_cnt_d = settle_cnt_q + 32'd1;
                end
            end

            default: begin
                // Unreachable encoding: fall back to the power-up settle.
                state_d      = ST_SETTLE;
                angle_d      = LOCK_POS;
                target_d     = LOCK_POS;
                settle_cnt_d = 32'd0;
                step_cnt_d   = 32'd0;
                locked_d     = 1'b0;
                unlocked_d   = 1'b0;
            end
        endcase

        // Handshake/status flags follow the next state so they are registered
        // in lockstep with it.
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers; reset starts the power-up settle at LOCK_POS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_SETTLE;
            angle_q      <= LOCK_POS;
            target_q     <= LOCK_POS;
            step_cnt_q   <= 32'd0;
            settle_cnt_q <= 32'd0;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            locked_q     <= 1'b0;
            unlocked_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            angle_q      <= angle_d;
            target_q     <= target_d;
            step_cnt_q   <= step_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            locked_q     <= locked_d;
            unlocked_q   <= unlocked_d;
            done_q       <= done_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign angle_pos = angle_q;
    assign busy      = busy_q;
    assign locked    = locked_q;
    assign unlocked  = unlocked_q;
    assign done      = done_q;

endmodule
